// File: rtl/ysyx_220053_exu_mc.sv
// Multi-cycle execute unit: integer regfile, single-cycle ALU,
// iterative shift-add multiplier and restoring divider.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_valid / in_ready   decode handshake (ready only when IDLE)
//   rd, rs1, rs2, wen     register addresses and write enable
//   alu_src_b, alu_op     operand B select, operation select
//   imm                   sign-extended immediate
//   out_valid             one-cycle completion pulse
//   out_rd/out_wen/out_data  completed instruction report
//   busy                  iterative op in progress
//   dbg_addr / dbg_data   combinational register read for debug
module ysyx_220053_exu_mc #(
  parameter int XLEN = 64,
  parameter int NREG = 32,
  parameter int RAW  = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [RAW-1:0]  rd,
  input  logic [RAW-1:0]  rs1,
  input  logic [RAW-1:0]  rs2,
  input  logic            wen,
  input  logic            alu_src_b,
  input  logic [3:0]      alu_op,
  input  logic [XLEN-1:0] imm,
  output logic            out_valid,
  output logic [RAW-1:0]  out_rd,
  output logic            out_wen,
  output logic [XLEN-1:0] out_data,
  output logic            busy,
  input  logic [RAW-1:0]  dbg_addr,
  output logic [XLEN-1:0] dbg_data
);

  localparam int SW = $clog2(XLEN);
  localparam int CW = SW + 1;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLL  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_SLT  = 4'd8;
  localparam logic [3:0] OP_SLTU = 4'd9;
  localparam logic [3:0] OP_MUL  = 4'd10;
  localparam logic [3:0] OP_DIVU = 4'd11;
  localparam logic [3:0] OP_REMU = 4'd12;

  typedef enum logic {
    S_IDLE,
    S_BUSY
  } state_e;

  state_e state_q, state_d;

  logic [XLEN-1:0] rf_q [NREG];

  logic [CW-1:0]   cnt_q, cnt_d;
  logic [3:0]      op_q, op_d;
  logic [RAW-1:0]  rd_q, rd_d;
  logic            wen_q, wen_d;
  // mul: a = multiplier (shifts right), b = multiplicand (shifts left),
  //      p = accumulator
  // div: a = dividend shifting out / quotient shifting in,
  //      b = divisor, p = partial remainder
  logic [XLEN-1:0] a_q, a_d;
  logic [XLEN-1:0] b_q, b_d;
  logic [XLEN-1:0] p_q, p_d;

  logic            out_valid_q, out_valid_d;
  logic [RAW-1:0]  out_rd_q, out_rd_d;
  logic            out_wen_q, out_wen_d;
  logic [XLEN-1:0] out_data_q, out_data_d;

  logic            wr_en;
  logic [RAW-1:0]  wr_addr;
  logic [XLEN-1:0] wr_data;

  logic [XLEN-1:0] opa, opb;
  logic [SW-1:0]   shamt;
  logic [XLEN-1:0] alu_res;
  logic            fire;
  logic            is_mul, is_div;
  logic            go_iter;
  logic            done;

  logic [XLEN-1:0] a_step, b_step, p_step;
  logic [XLEN:0]   trial, diff;
  logic            ge;
  logic [XLEN-1:0] iter_res;

  assign opa   = (rs1 == '0) ? '0 : rf_q[rs1];
  assign opb   = alu_src_b ? imm
               : ((rs2 == '0) ? '0 : rf_q[rs2]);
  assign shamt = opb[SW-1:0];

  assign in_ready = (state_q == S_IDLE);
  assign busy     = (state_q == S_BUSY);
  assign fire     = in_valid & in_ready;

  assign is_mul  = (alu_op == OP_MUL);
  assign is_div  = (alu_op == OP_DIVU)
                 | (alu_op == OP_REMU);
  // divide by zero finishes through the single-cycle path
  assign go_iter = fire
                 & (is_mul | (is_div & (opb != '0)));
  assign done    = (state_q == S_BUSY)
                 & (cnt_q == CW'(1));

  assign dbg_data = (dbg_addr == '0) ? '0 : rf_q[dbg_addr];

  assign out_valid = out_valid_q;
  assign out_rd    = out_rd_q;
  assign out_wen   = out_wen_q;
  assign out_data  = out_data_q;

  always_comb begin
    alu_res = '0;
    unique case (alu_op)
      OP_ADD:  alu_res = opa + opb;
      OP_SUB:  alu_res = opa - opb;
      OP_AND:  alu_res = opa & opb;
      OP_OR:   alu_res = opa | opb;
      OP_XOR:  alu_res = opa ^ opb;
      OP_SLL:  alu_res = opa << shamt;
      OP_SRL:  alu_res = opa >> shamt;
      OP_SRA:  alu_res = XLEN'($signed(opa) >>> shamt);
      OP_SLT:  alu_res = {{(XLEN-1){1'b0}},
                          $signed(opa) < $signed(opb)};
      OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, opa < opb};
      OP_DIVU: alu_res = '1;
      OP_REMU: alu_res = opa;
      default: alu_res = '0;
    endcase
  end

  // one iteration step of the mul/div engine
  always_comb begin
    trial  = {p_q, a_q[XLEN-1]};
    diff   = trial - {1'b0, b_q};
    ge     = (trial >= {1'b0, b_q});
    a_step = a_q;
    b_step = b_q;
    p_step = p_q;
    if (op_q == OP_MUL) begin
      p_step = p_q + (a_q[0] ? b_q : '0);
      a_step = a_q >> 1;
      b_step = b_q << 1;
    end else begin
      p_step = ge ? diff[XLEN-1:0] : trial[XLEN-1:0];
      a_step = {a_q[XLEN-2:0], ge};
    end
    iter_res = (op_q == OP_DIVU) ? a_step : p_step;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    rd_d        = rd_q;
    wen_d       = wen_q;
    a_d         = a_q;
    b_d         = b_q;
    p_d         = p_q;
    out_valid_d = 1'b0;
    out_rd_d    = out_rd_q;
    out_wen_d   = out_wen_q;
    out_data_d  = out_data_q;
    wr_en       = 1'b0;
    wr_addr     = '0;
    wr_data     = '0;
    unique case (state_q)
      S_IDLE: begin
        if (go_iter) begin
          state_d = S_BUSY;
          cnt_d   = CW'(XLEN);
          op_d    = alu_op;
          rd_d    = rd;
          wen_d   = wen & (rd != '0);
          p_d     = '0;
          a_d     = is_mul ? opb : opa;
          b_d     = is_mul ? opa : opb;
        end else if (fire) begin
          wr_en       = wen & (rd != '0);
          wr_addr     = rd;
          wr_data     = alu_res;
          out_valid_d = 1'b1;
          out_rd_d    = rd;
          out_wen_d   = wen & (rd != '0);
          out_data_d  = alu_res;
        end
      end
      S_BUSY: begin
        cnt_d = cnt_q - CW'(1);
        a_d   = a_step;
        b_d   = b_step;
        p_d   = p_step;
        if (done) begin
          state_d     = S_IDLE;
          wr_en       = wen_q;
          wr_addr     = rd_q;
          wr_data     = iter_res;
          out_valid_d = 1'b1;
          out_rd_d    = rd_q;
          out_wen_d   = wen_q;
          out_data_d  = iter_res;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      op_q        <= '0;
      rd_q        <= '0;
      wen_q       <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      p_q         <= '0;
      out_valid_q <= 1'b0;
      out_rd_q    <= '0;
      out_wen_q   <= 1'b0;
      out_data_q  <= '0;
      for (int i = 0; i < NREG; i++) begin
        rf_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      rd_q        <= rd_d;
      wen_q       <= wen_d;
      a_q         <= a_d;
      b_q         <= b_d;
      p_q         <= p_d;
      out_valid_q <= out_valid_d;
      out_rd_q    <= out_rd_d;
      out_wen_q   <= out_wen_d;
      out_data_q  <= out_data_d;
      if (wr_en) begin
        rf_q[wr_addr] <= wr_data;
      end
    end
  end

endmodule
